// File: rtl/matmul_dma_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_dma_if
// Description : Avalon-MM master bus between the matmul DMA and DDR.
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_dma_if #(
    parameter int BURST = 16
);
    localparam int BC_W = $clog2(BURST) + 1;

    logic [31:0]     avm_address;
    logic [BC_W-1:0] avm_burstcount;
    logic            avm_read;
    logic            avm_write;
    logic [31:0]     avm_writedata;
    logic            avm_waitrequest;
    logic [31:0]     avm_readdata;
    logic            avm_readdatavalid;

    modport master (
        output avm_address, avm_burstcount, avm_read, avm_write, avm_writedata,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_burstcount, avm_read, avm_write, avm_writedata,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/matmul_dma.sv
`default_nettype none
// ============================================================================
// Module      : matmul_dma
// Description : Moves N*N-word matrices between DDR and the A/B/C tile buffers.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_dma #(
    parameter int N     = 16,
    parameter int BURST = 16,
    parameter int IDX_W = $clog2(N*N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_load_a,
    input  logic             start_load_b,
    input  logic             start_store_c,
    input  logic [31:0]      addr_a,
    input  logic [31:0]      addr_b,
    input  logic [31:0]      addr_c,
    output logic             done,
    output logic             busy,
    matmul_dma_if.master     avm,
    output logic             a_wr_en,
    output logic             b_wr_en,
    output logic [IDX_W-1:0] buf_wr_addr,
    output logic [31:0]      buf_wr_data,
    output logic [IDX_W-1:0] c_rd_addr,
    input  logic [31:0]      c_rd_data
);
    localparam int K_W   = IDX_W + 1;
    localparam int BC_W  = $clog2(BURST) + 1;
    localparam int SHIFT = $clog2(BURST * 4);

    localparam logic [K_W-1:0] C_TOTAL = K_W'(N * N);
    localparam logic [K_W-1:0] C_BURST = K_W'(BURST);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_REQ   = 3'd1;
    localparam logic [2:0] S_RD_DATA  = 3'd2;
    localparam logic [2:0] S_WR_FETCH = 3'd3;
    localparam logic [2:0] S_WR_BEAT  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [1:0] CMD_A = 2'd0;
    localparam logic [1:0] CMD_B = 2'd1;
    localparam logic [1:0] CMD_C = 2'd2;

    logic [2:0]     r_state;
    logic [2:0]     w_state_next;
    logic [1:0]     r_cmd;
    logic [31:0]    r_base;
    logic [K_W-1:0] r_k;
    logic [K_W-1:0] r_j;
    logic [31:0]    r_wdata;
    logic           r_wfirst;
    logic           r_busy;

    logic [K_W-1:0] w_k_next;
    logic           w_last;
    logic           w_burst_end;
    logic           w_rd_beat;
    logic           w_wr_acc;
    logic           w_start_any;
    logic [31:0]    w_sel_base;
    logic [1:0]     w_sel_cmd;

    assign w_k_next    = r_k + K_W'(1);
    assign w_last      = (w_k_next == C_TOTAL);
    assign w_burst_end = ((w_k_next % C_BURST) == '0);
    assign w_rd_beat   = (r_state == S_RD_DATA) && avm.avm_readdatavalid;
    assign w_wr_acc    = (r_state == S_WR_BEAT) && !avm.avm_waitrequest;
    assign w_start_any = start_load_a || start_load_b || start_store_c;

    // A beats B beats C when several starts coincide
    always_comb begin
        w_sel_base = addr_c;
        w_sel_cmd  = CMD_C;
        if (start_load_a) begin
            w_sel_base = addr_a;
            w_sel_cmd  = CMD_A;
        end else if (start_load_b) begin
            w_sel_base = addr_b;
            w_sel_cmd  = CMD_B;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_load_a || start_load_b) w_state_next = S_RD_REQ;
                else if (start_store_c)           w_state_next = S_WR_FETCH;
            end
            S_RD_REQ:   if (!avm.avm_waitrequest) w_state_next = S_RD_DATA;
            S_RD_DATA:  if (w_rd_beat && w_burst_end) w_state_next = w_last ? S_DONE : S_RD_REQ;
            S_WR_FETCH: w_state_next = S_WR_BEAT;
            S_WR_BEAT:  if (w_wr_acc) w_state_next = w_last ? S_DONE : S_WR_FETCH;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cmd    <= CMD_A;
            r_base   <= '0;
            r_k      <= '0;
            r_j      <= '0;
            r_wdata  <= '0;
            r_wfirst <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE) && (w_state_next != S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_start_any) begin
                        r_cmd  <= w_sel_cmd;
                        r_base <= {w_sel_base[31:2], 2'b00};
                        r_k    <= '0;
                        r_j    <= '0;
                    end
                end
                S_RD_DATA: begin
                    if (w_rd_beat) begin
                        r_k <= w_k_next;
                        if (w_burst_end && !w_last) r_j <= r_j + K_W'(1);
                    end
                end
                S_WR_FETCH: r_wfirst <= 1'b1;
                S_WR_BEAT: begin
                    // C buffer data is only valid in the first beat cycle; hold it for stalls
                    r_wfirst <= 1'b0;
                    if (r_wfirst) r_wdata <= c_rd_data;
                    if (w_wr_acc) begin
                        r_k <= w_k_next;
                        if (w_burst_end && !w_last) r_j <= r_j + K_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign avm.avm_address    = r_base + (32'(r_j) << SHIFT);
    assign avm.avm_read       = (r_state == S_RD_REQ);
    assign avm.avm_write      = (r_state == S_WR_BEAT);
    assign avm.avm_burstcount = (avm.avm_read || avm.avm_write) ? BC_W'(BURST) : '0;
    assign avm.avm_writedata  = !avm.avm_write ? 32'd0 : (r_wfirst ? c_rd_data : r_wdata);

    assign a_wr_en     = w_rd_beat && (r_cmd == CMD_A);
    assign b_wr_en     = w_rd_beat && (r_cmd == CMD_B);
    assign buf_wr_addr = r_k[IDX_W-1:0];
    assign buf_wr_data = w_rd_beat ? avm.avm_readdata : 32'd0;
    assign c_rd_addr   = (r_state == S_WR_FETCH) ? r_k[IDX_W-1:0] : '0;
    assign done        = (r_state == S_DONE);
    assign busy        = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_matmul_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_dma
// Description : Scoreboard bench for matmul_dma with an Avalon slave and tile RAMs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_dma;
    localparam int N     = 16;
    localparam int BURST = 16;
    localparam int WORDS = N * N;
    localparam int IDX_W = $clog2(WORDS);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_load_a = 1'b0;
    logic             start_load_b = 1'b0;
    logic             start_store_c = 1'b0;
    logic [31:0]      addr_a = '0;
    logic [31:0]      addr_b = '0;
    logic [31:0]      addr_c = '0;
    logic             done;
    logic             busy;
    logic             a_wr_en;
    logic             b_wr_en;
    logic [IDX_W-1:0] buf_wr_addr;
    logic [31:0]      buf_wr_data;
    logic [IDX_W-1:0] c_rd_addr;
    logic [31:0]      c_rd_data = '0;

    matmul_dma_if #(.BURST(BURST)) avm ();

    matmul_dma #(.N(N), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .start_load_a(start_load_a), .start_load_b(start_load_b), .start_store_c(start_store_c),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
        .done(done), .busy(busy), .avm(avm),
        .a_wr_en(a_wr_en), .b_wr_en(b_wr_en),
        .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] amem [WORDS];
    logic [31:0] bmem [WORDS];
    logic [31:0] cmem [WORDS];

    logic [31:0] q_rd_addr [$];
    logic [31:0] q_seen    [$];
    int          q_bidx    [$];
    logic [31:0] q_bdat    [$];
    logic [31:0] q_wa      [$];
    logic [31:0] q_wd      [$];

    int          rd_stall  = 0;
    bit          rd_gap    = 1'b0;
    bit          wr_toggle = 1'b0;
    logic [31:0] rd_pat    = '0;
    int          rd_idx    = 0;
    int          pending   = 0;
    int          stall_cnt = 0;
    int          gap_ctr   = 0;
    logic [IDX_W-1:0] ra_q = '0;

    int a_cnt = 0, b_cnt = 0, w_cnt = 0, done_cnt = 0, w_at_done = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Avalon slave and synchronous C RAM, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        c_rd_data = cmem[ra_q];
        if (!rst) begin
            pending = 0; stall_cnt = 0; gap_ctr = 0;
            avm.avm_waitrequest = 1'b0; avm.avm_readdatavalid = 1'b0; avm.avm_readdata = '0;
        end else begin
            if (avm.avm_read) begin
                if (stall_cnt < rd_stall) begin
                    avm.avm_waitrequest = 1'b1; stall_cnt++;
                end else begin
                    avm.avm_waitrequest = 1'b0; stall_cnt = 0;
                end
            end else if (wr_toggle) avm.avm_waitrequest = ~avm.avm_waitrequest;
            else avm.avm_waitrequest = 1'b0;
            avm.avm_readdatavalid = 1'b0;
            if (pending > 0) begin
                if (rd_gap && gap_ctr == 2) gap_ctr = 0;
                else begin
                    avm.avm_readdatavalid = 1'b1;
                    avm.avm_readdata = rd_pat + 32'(rd_idx);
                    q_bidx.push_back(rd_idx);
                    q_bdat.push_back(rd_pat + 32'(rd_idx));
                    rd_idx++; pending--;
                    if (rd_gap) gap_ctr++;
                end
            end
        end
    end

    // Monitor: mid-cycle sampling of every DUT output
    always @(negedge clk) begin
        ra_q = c_rd_addr;
        if (rst) begin
            if (avm.avm_read) begin
                if (q_rd_addr.size() == 0) check("rd_unexpected", 64'(avm.avm_address), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    check("rd_addr", 64'(avm.avm_address), 64'(q_rd_addr[0]));
                    check("rd_bcount", 64'(avm.avm_burstcount), 64'(BURST));
                    if (!avm.avm_waitrequest) begin
                        q_seen.push_back(avm.avm_address);
                        void'(q_rd_addr.pop_front());
                        pending = BURST;
                    end
                end
            end
            if (a_wr_en || b_wr_en) begin
                check("strobe_excl", 64'(a_wr_en & b_wr_en), 64'd0);
                if (a_wr_en) begin a_cnt++; amem[buf_wr_addr] = buf_wr_data; end
                else begin b_cnt++; bmem[buf_wr_addr] = buf_wr_data; end
                if (q_bidx.size() == 0) check("beat_unexpected", 64'(buf_wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    check("buf_idx", 64'(buf_wr_addr), 64'(q_bidx.pop_front()));
                    check("buf_data", 64'(buf_wr_data), 64'(q_bdat.pop_front()));
                end
            end
            if (avm.avm_write) begin
                if (q_wa.size() == 0) check("wr_unexpected", 64'(avm.avm_address), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    check("wr_addr", 64'(avm.avm_address), 64'(q_wa[0]));
                    check("wr_data", 64'(avm.avm_writedata), 64'(q_wd[0]));
                    if (!avm.avm_waitrequest) begin
                        void'(q_wa.pop_front()); void'(q_wd.pop_front()); w_cnt++;
                    end
                end
            end
            if (done) begin
                done_cnt++; w_at_done = w_cnt;
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic clear_stats();
        a_cnt = 0; b_cnt = 0; w_cnt = 0; done_cnt = 0; w_at_done = 0; rd_idx = 0;
        q_rd_addr.delete(); q_seen.delete(); q_bidx.delete(); q_bdat.delete();
        q_wa.delete(); q_wd.delete();
        for (int i = 0; i < WORDS; i++) begin amem[i] = '0; bmem[i] = '0; end
    endtask

    task automatic expect_reads(input logic [31:0] base);
        for (int j = 0; j < WORDS / BURST; j++)
            q_rd_addr.push_back({base[31:2], 2'b00} + 32'(j * BURST * 4));
    endtask

    task automatic pulse(input bit a, input bit b, input bit c, input string tag);
        @(posedge clk); #2;
        start_load_a = a; start_load_b = b; start_store_c = c;
        @(posedge clk); #2;
        start_load_a = 1'b0; start_load_b = 1'b0; start_store_c = 1'b0;
        @(negedge clk);
        check({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin @(posedge clk); cyc++; end
        check({tag, "_timeout"}, 64'(done_cnt == 0), 64'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_rd_left"}, 64'(q_rd_addr.size()), 64'd0);
        check({tag, "_beats_left"}, 64'(q_bidx.size()), 64'd0);
        check({tag, "_wr_left"}, 64'(q_wa.size()), 64'd0);
    endtask

    task automatic check_mem(input string tag, input bit is_a, input logic [31:0] pat);
        int errs = 0;
        for (int i = 0; i < WORDS; i++)
            if ((is_a ? amem[i] : bmem[i]) !== pat + 32'(i)) errs++;
        check(tag, 64'(errs), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        logic [63:0] v;
        v = {avm.avm_address | avm.avm_writedata | buf_wr_data,
             16'(buf_wr_addr) | 16'(c_rd_addr), 8'(avm.avm_burstcount),
             done, busy, avm.avm_read, avm.avm_write, a_wr_en, b_wr_en, 2'b00};
        check(tag, v, 64'd0);
    endtask

    task automatic load(input bit is_a, input logic [31:0] base, input logic [31:0] pat, input string tag);
        clear_stats();
        rd_pat = pat;
        expect_reads(base);
        if (is_a) addr_a = base; else addr_b = base;
        pulse(is_a, !is_a, 1'b0, tag);
        wait_done(tag);
        check({tag, "_a_cnt"}, 64'(a_cnt), is_a ? 64'(WORDS) : 64'd0);
        check({tag, "_b_cnt"}, 64'(b_cnt), is_a ? 64'd0 : 64'(WORDS));
        check_mem({tag, "_mem"}, is_a, pat);
    endtask

    initial begin
        avm.avm_waitrequest = 1'b0; avm.avm_readdata = '0; avm.avm_readdatavalid = 1'b0;
        for (int i = 0; i < WORDS; i++) cmem[i] = 32'(i * 3);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b1;

        load(1'b1, 32'h1000_0002, 32'hA000_0000, "load_a");

        rd_stall = 5; rd_gap = 1'b1;
        load(1'b0, 32'h3000_0000, 32'hB000_0000, "load_b_stall");
        rd_stall = 0; rd_gap = 1'b0;

        clear_stats();
        wr_toggle = 1'b1;
        addr_c = 32'h2000_0000;
        for (int i = 0; i < WORDS; i++) begin
            q_wa.push_back(32'h2000_0000 + 32'((i / BURST) * BURST * 4));
            q_wd.push_back(32'(i * 3));
        end
        pulse(1'b0, 1'b0, 1'b1, "store_c");
        wait_done("store_c");
        check("store_c_beats", 64'(w_cnt), 64'(WORDS));
        check("store_c_done_after_last", 64'(w_at_done), 64'(WORDS));
        check("store_c_no_strobe", 64'(a_cnt + b_cnt), 64'd0);
        wr_toggle = 1'b0;

        clear_stats();
        rd_pat = 32'h1111_0000;
        addr_a = 32'h4000_0000; addr_b = 32'h5000_0000; addr_c = 32'h6000_0000;
        expect_reads(32'h4000_0000);
        pulse(1'b1, 1'b1, 1'b1, "prio");
        begin
            int cyc = 0;
            while (a_cnt < 100 && cyc < 5000) begin @(negedge clk); cyc++; end
            check("prio_reach_mid", 64'(a_cnt >= 100), 64'd1);
        end
        pulse(1'b0, 1'b0, 1'b1, "prio_mid_start");
        wait_done("prio");
        check("prio_a_cnt", 64'(a_cnt), 64'(WORDS));
        check("prio_b_cnt", 64'(b_cnt), 64'd0);
        check("prio_no_write", 64'(w_cnt), 64'd0);
        check_mem("prio_mem", 1'b1, 32'h1111_0000);

        load(1'b0, 32'hFFFF_FFC0, 32'h0BAD_0000, "wrap");
        check("wrap_burst0_addr", 64'(q_seen.size() > 1 ? q_seen[0] : 32'hDEAD_BEEF), 64'hFFFF_FFC0);
        check("wrap_burst1_addr", 64'(q_seen.size() > 1 ? q_seen[1] : 32'hDEAD_BEEF), 64'h0000_0000);

        clear_stats();
        rd_pat = 32'h7777_0000;
        addr_a = 32'h7000_0000;
        expect_reads(32'h7000_0000);
        pulse(1'b1, 1'b0, 1'b0, "rst_mid");
        begin
            int cyc = 0;
            while (a_cnt < 37 && cyc < 5000) begin @(negedge clk); cyc++; end
            check("rst_mid_reach_k37", 64'(a_cnt), 64'd37);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        #1 check_zero("rst_mid_async_zero");
        repeat (2) @(negedge clk);
        check_zero("rst_mid_held_zero");
        rst = 1'b1;
        load(1'b1, 32'h7000_0000, 32'hC000_0000, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
